oam_dma_ctrl: RTL

- OAM DMA controller and main-bus arbiter. Sits between the CPU and the shared memory bus.
- Owns register FF46. A write to FF46 starts a 160-byte copy from {src,00}–{src,9F} into OAM through a dedicated OAM write port.
- While DMA is active, the block owns the main bus and confines the CPU to HRAM (FF80–FFFE) via a separate HRAM path, plus FF46.

---
 rtl/oam_dma_ctrl_if.sv | 42 ++++
 rtl/oam_dma_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_ctrl_if
// Purpose  : Bundles the signals between the OAM DMA controller and the CPU,
//            the main memory bus, HRAM and the OAM write port.
//            The slave modport is the controller's view of the bundle.
//            The master modport is the view of the CPU and memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_do_write;
  logic [7:0]  cpu_data_r;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_w;
  logic        bus_do_write;
  logic [7:0]  bus_data_r;
  logic [6:0]  hram_addr;
  logic [7:0]  hram_data_w;
  logic        hram_do_write;
  logic [7:0]  hram_data_r;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_data_w, cpu_do_write, bus_data_r, hram_data_r,
    output cpu_data_r, bus_addr, bus_data_w, bus_do_write,
    output hram_addr, hram_data_w, hram_do_write,
    output oam_addr, oam_data, oam_we, dma_active
  );

  modport master (
    output cpu_addr, cpu_data_w, cpu_do_write, bus_data_r, hram_data_r,
    input  cpu_data_r, bus_addr, bus_data_w, bus_do_write,
    input  hram_addr, hram_data_w, hram_do_write,
    input  oam_addr, oam_data, oam_we, dma_active
  );
endinterface
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_ctrl
// Purpose  : OAM DMA controller and main-bus arbiter.
//            A write to FF46 copies BYTES bytes from {src,00} into OAM.
//            While the copy runs, the CPU is confined to HRAM and FF46.
// Options  : OAM_DMA_BUS_CONFLICT_EN - when defined, a blocked CPU read
//            during DMA returns the byte DMA is reading. Otherwise the
//            blocked read returns 8'hFF.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl #(
  parameter int BYTES          = 160,
  parameter int STARTUP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  oam_dma_ctrl_if.slave bus_if
);

  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_START      = 2'd1;
  localparam logic [1:0]  c_XFER       = 2'd2;
  localparam logic [1:0]  c_DRAIN      = 2'd3;
  localparam logic [15:0] c_FF46_ADDR  = 16'hFF46;
  localparam logic [7:0]  c_LAST_IDX   = 8'(BYTES - 1);
  localparam logic [3:0]  c_START_LAST = 4'(STARTUP_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_src;
  logic [7:0] r_idx;
  logic [3:0] r_start_cnt;
  logic       r_oam_we;
  logic [7:0] r_oam_addr;
  logic [7:0] r_oam_data;

  logic       w_ff46_hit;
  logic       w_ff46_wr;
  logic       w_hram_hit;
  logic       w_capture;
  logic       w_active;
  logic [7:0] w_eff_src;

  assign w_ff46_hit = (bus_if.cpu_addr == c_FF46_ADDR);
  assign w_ff46_wr  = w_ff46_hit && bus_if.cpu_do_write;
  assign w_hram_hit = (bus_if.cpu_addr >= 16'hFF80) && (bus_if.cpu_addr != 16'hFFFF);
  assign w_active   = (r_state != c_IDLE);
  // Sources in the echo range E0..FF fold back onto WRAM C0..DF.
  assign w_eff_src  = (r_src < 8'hE0) ? r_src : (r_src - 8'h20);
  // A restart discards the byte being read this cycle.
  assign w_capture  = (r_state == c_XFER) && !w_ff46_wr;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. An FF46 write (re)starts the transfer from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ff46_wr) begin
      w_state_nxt = c_START;
    end else begin
      case (r_state)
        c_IDLE:  w_state_nxt = c_IDLE;
        c_START: w_state_nxt = (r_start_cnt == c_START_LAST) ? c_XFER : c_START;
        c_XFER:  w_state_nxt = (r_idx == c_LAST_IDX) ? c_DRAIN : c_XFER;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  // Source latch, startup counter and source index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src       <= 8'h00;
      r_idx       <= 8'h00;
      r_start_cnt <= 4'd0;
    end else if (w_ff46_wr) begin
      r_src       <= bus_if.cpu_data_w;
      r_idx       <= 8'h00;
      r_start_cnt <= 4'd0;
    end else begin
      if (r_state == c_START) begin
        r_start_cnt <= r_start_cnt + 4'd1;
      end
      if ((r_state == c_XFER) && (r_idx != c_LAST_IDX)) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  // OAM write stage: each read byte is written one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_oam_we   <= 1'b0;
      r_oam_addr <= 8'h00;
      r_oam_data <= 8'h00;
    end else begin
      r_oam_we <= w_capture;
      if (w_capture) begin
        r_oam_addr <= r_idx;
        r_oam_data <= bus_if.bus_data_r;
      end
    end
  end

  // Output decode: bus ownership, HRAM path and CPU read mux.
  always_comb begin
    bus_if.bus_data_w    = bus_if.cpu_data_w;
    bus_if.hram_addr     = bus_if.cpu_addr[6:0];
    bus_if.hram_data_w   = bus_if.cpu_data_w;
    bus_if.hram_do_write = bus_if.cpu_do_write && w_hram_hit;
    bus_if.bus_addr      = bus_if.cpu_addr;
    bus_if.bus_do_write  = 1'b0;
    bus_if.dma_active    = w_active;
    bus_if.oam_we        = r_oam_we;
    bus_if.oam_addr      = r_oam_addr;
    bus_if.oam_data      = r_oam_data;
    case (r_state)
      c_IDLE:  bus_if.bus_do_write = bus_if.cpu_do_write && !w_ff46_hit;
      c_START: bus_if.bus_addr     = {w_eff_src, 8'h00};
      // DRAIN keeps the last source address on the bus.
      default: bus_if.bus_addr     = {w_eff_src, r_idx};
    endcase
    if (w_hram_hit) begin
      bus_if.cpu_data_r = bus_if.hram_data_r;
    end else if (w_ff46_hit) begin
      bus_if.cpu_data_r = r_src;
    end else if (!w_active) begin
      bus_if.cpu_data_r = bus_if.bus_data_r;
    end else begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
      bus_if.cpu_data_r = bus_if.bus_data_r;
`else
      bus_if.cpu_data_r = 8'hFF;
`endif
    end
  end

endmodule
`default_nettype wire
